// File: rtl/call_stack.sv
// call_stack: hardware return-address stack.
// A call pushes the return address and a RET pops it. The top of the stack is
// available combinationally so the PC mux can use it in the same cycle as the
// pop. Refused pushes and pops set sticky error flags that only reset clears.
module call_stack #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pcIn,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic [PTR_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The write port has no reset because its contents are don't-care after reset.
    logic [ADDR_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] sp_reg;
    logic [PTR_W-1:0] sp_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    // sp always equals the number of valid entries.
    // The top entry is at sp-1.
    assign top_idx   = IDX_W'(sp_reg - 1'b1);
    assign empty     = (sp_reg == '0);
    assign full      = (sp_reg == PTR_W'(DEPTH));
    assign count     = sp_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign top       = empty ? '0 : mem[top_idx];

    // Decode push/pop into a storage write and the next pointer and flag values.
    always_comb begin
        sp_next        = sp_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        wr_en          = 1'b0;
        wr_idx         = '0;
        if (push && pop) begin
            // Push and pop together replace the top entry.
            // When the stack is empty, this behaves like a plain push.
            wr_en = 1'b1;
            if (empty) begin
                wr_idx  = '0;
                sp_next = PTR_W'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (full) begin
                overflow_next = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = IDX_W'(sp_reg);
                sp_next = sp_reg + 1'b1;
            end
        end else if (pop) begin
            // Popped data stays in the array and is simply no longer referenced.
            if (empty) begin
                underflow_next = 1'b1;
            end else begin
                sp_next = sp_reg - 1'b1;
            end
        end
    end

    // Pointer and sticky error flags, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_reg        <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg        <= sp_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Return-address storage write port.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_idx] <= pcIn;
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Testbench for call_stack.
// It runs directed scenarios and then randomized push/pop traffic. Results are
// compared against a queue-based stack model.
module tb_call_stack;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;
    localparam int PTR_W  = 4;

    logic              clk;
    logic              rst;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pcIn;
    logic [ADDR_W-1:0] top;
    logic              empty;
    logic              full;
    logic [PTR_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of return addresses plus two sticky flags.
    logic [ADDR_W-1:0] stk[$];
    logic              m_ovf;
    logic              m_unf;

    call_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .pcIn      (pcIn),
        .top       (top),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input logic p, input logic q, input logic [ADDR_W-1:0] d);
        if (p && q) begin
            if (stk.size() == 0) stk.push_back(d);
            else stk[stk.size()-1] = d;
        end else if (p) begin
            if (stk.size() == DEPTH) m_ovf = 1'b1;
            else stk.push_back(d);
        end else if (q) begin
            if (stk.size() == 0) m_unf = 1'b1;
            else void'(stk.pop_back());
        end
    endtask

    task automatic compare_all(input string tag);
        logic [ADDR_W-1:0] exp_top;
        exp_top = (stk.size() == 0) ? '0 : stk[stk.size()-1];
        check({tag, "_top"},   32'(top),       32'(exp_top));
        check({tag, "_count"}, 32'(count),     32'(stk.size()));
        check({tag, "_empty"}, 32'(empty),     32'(stk.size() == 0));
        check({tag, "_full"},  32'(full),      32'(stk.size() == DEPTH));
        check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
        check({tag, "_unf"},   32'(underflow), 32'(m_unf));
    endtask

    // Apply one operation for one clock edge, update the model, and compare just after the edge.
    task automatic step(input string tag, input logic p, input logic q, input logic [ADDR_W-1:0] d);
        @(negedge clk);
        push = p;
        pop  = q;
        pcIn = d;
        @(posedge clk);
        model_apply(p, q, d);
        #1;
        $display("op %s push=%0d pop=%0d pcIn=0x%03h -> top=0x%03h count=%0d ovf=%0d unf=%0d",
                 tag, p, q, d, top, count, overflow, underflow);
        compare_all(tag);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Assert reset mid-cycle with push high.
    // Outputs are checked before any clock edge, so only an asynchronous clear can make them match.
    task automatic async_reset(input string tag);
        @(negedge clk);
        push = 1'b1;
        pcIn = ADDR_W'($urandom);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        $display("op %s async reset -> count=%0d empty=%0d", tag, count, empty);
        compare_all(tag);
        @(negedge clk);
        push = 1'b0;
        rst  = 1'b1;
    endtask

    initial begin
        logic p, q;
        int r;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        pcIn = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // 1. Reset state after two idle cycles.
        compare_all("reset");
        check("reset_top_const", 32'(top), 32'h0);

        // 2. Basic push/pop ordering.
        step("t2_push", 1, 0, 12'h010);
        step("t2_push", 1, 0, 12'h020);
        step("t2_push", 1, 0, 12'h030);
        check("t2_top_const", 32'(top), 32'h030);
        step("t2_pop", 0, 1, 12'h000);
        check("t2_pop1_const", 32'(top), 32'h020);
        step("t2_pop", 0, 1, 12'h000);
        check("t2_pop2_const", 32'(top), 32'h010);
        step("t2_pop", 0, 1, 12'h000);
        check("t2_empty_const", 32'(empty), 32'h1);

        // 3. Fill the stack, then push once more to overflow it.
        for (int i = 0; i < DEPTH; i++) step("t3_fill", 1, 0, ADDR_W'(12'h100 + i));
        check("t3_full_const", 32'(full), 32'h1);
        step("t3_over", 1, 0, 12'hABC);
        check("t3_top_const", 32'(top), 32'h107);
        check("t3_ovf_const", 32'(overflow), 32'h1);
        step("t3_pop", 0, 1, 12'h000);
        check("t3_pop_const", 32'(top), 32'h106);

        // 4. Pop from an empty stack, then push.
        async_reset("t4_rst");
        step("t4_under", 0, 1, 12'h000);
        check("t4_unf_const", 32'(underflow), 32'h1);
        step("t4_push", 1, 0, 12'h055);
        check("t4_top_const", 32'(top), 32'h055);

        // 5. Push and pop in the same cycle.
        async_reset("t5_rst");
        step("t5_push", 1, 0, 12'h011);
        step("t5_push", 1, 0, 12'h022);
        step("t5_repl", 1, 1, 12'h0FF);
        check("t5_repl_const", 32'(top), 32'h0FF);
        step("t5_pop", 0, 1, 12'h000);
        check("t5_pop_const", 32'(top), 32'h011);
        step("t5_pop", 0, 1, 12'h000);
        step("t5_emptyrepl", 1, 1, 12'h033);
        check("t5_er_unf_const", 32'(underflow), 32'h0);
        check("t5_er_top_const", 32'(top), 32'h033);

        // Replace while the stack is full must not set overflow.
        for (int i = 0; i < DEPTH; i++) step("t5_fill", 1, 0, ADDR_W'($urandom));
        step("t5_fullrepl", 1, 1, 12'h5A5);

        // 6. Asynchronous reset while count is 5 and push is high.
        async_reset("t6_rst0");
        for (int i = 0; i < 5; i++) step("t6_fill", 1, 0, ADDR_W'(12'h200 + i));
        async_reset("t6_rst");
        check("t6_count_const", 32'(count), 32'h0);
        step("t6_push", 1, 0, 12'h0AA);
        check("t6_top_const", 32'(top), 32'h0AA);

        // Randomized traffic, alternating push-heavy and pop-heavy phases, with rare resets.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                async_reset("rnd_rst");
            end else begin
                if (((i / 40) % 2) == 0) begin
                    p = (r < 65);
                    q = (r >= 55 && r < 80);
                end else begin
                    p = (r < 30);
                    q = (r >= 20 && r < 85);
                end
                step("rnd", p, q, ADDR_W'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net in case the clock-driven stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack; the responder to the controller's push/pop/RET stack-control outputs.
- On a call, the controller asserts push and the datapath supplies the return address; the stack stores it.
- On RET, the controller asserts pop and the stack presents the saved address to the PC mux.
- Sits beside the PC register in the datapath and reports overflow/underflow errors.

Parameters:
- DEPTH, 8, number of return-address entries (power of 2, at least 2).
- ADDR_W, 12, width of a stored program address.
- PTR_W, 4, stack-pointer width; must satisfy 2^PTR_W > DEPTH.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  store pcIn on this rising edge.
- pop  input  1  discard the top entry on this rising edge.
- pcIn  input  ADDR_W  return address to push (PC+1, from the datapath).
- top  output  ADDR_W  current top-of-stack address (combinational from state).
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.
- count  output  PTR_W  number of valid entries.
- overflow  output  1  sticky: a push was refused because the stack was full.
- underflow  output  1  sticky: a pop was refused because the stack was empty.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - sp/count = 0, overflow = 0, underflow = 0.
  - Storage contents are don't-care; top = 0, empty = 1, full = 0.
- State: storage array mem[0..DEPTH-1]; sp = count; the top entry is mem[sp-1].
- top = empty ? 0 : mem[sp-1]. top is combinational from registered state, so a RET can sample it in the same cycle pop is asserted.
- Sampled at each rising clk edge with rst high:
  - push=1, pop=0, not full: mem[sp] <= pcIn; sp <= sp+1.
  - push=1, pop=0, full: no write; sp unchanged; overflow <= 1.
  - push=0, pop=1, not empty: sp <= sp-1 (entry data left in place).
  - push=0, pop=1, empty: sp stays 0; underflow <= 1.
  - push=1, pop=1, not empty: replace top, i.e. mem[sp-1] <= pcIn; sp unchanged; no flag change, even when full.
  - push=1, pop=1, empty: treated as a plain push (mem[0] <= pcIn, sp <= 1); no underflow.
  - push=0, pop=0: hold.
- overflow and underflow stay set until reset; there is no other clear path.
- Latency:
  - A pushed value appears on top one edge after the push, i.e. immediately after that edge.
  - After a pop, top shows the next-older entry right after the edge.
- count, empty and full are updated on the same edge as sp.
- Wrap-around: sp never wraps. Every saturation case goes through the refuse-and-flag rules above.
- Reset during any operation: the asynchronous clear wins over any push/pop on that edge.
- X-safety: push/pop are treated as 0 while rst is low; pcIn is ignored unless a write occurs.

Test Plan:
1. Reset, then idle 2 cycles -> empty=1, full=0, count=0, top=0, overflow=0, underflow=0.
2. Push 0x010, 0x020, 0x030 on consecutive edges -> count=3, top=0x030. Then pop three times -> top goes 0x020, 0x010, 0; empty=1 after the third pop; no flags set.
3. Push 8 values 0x100..0x107 -> full=1, top=0x107. A 9th push of 0xABC -> count stays 8, top=0x107, overflow=1. A subsequent pop -> top=0x106, overflow still 1.
4. From reset, pop with the stack empty -> count=0, top=0, underflow=1. Then push 0x055 -> top=0x055, count=1, underflow still 1.
5. Simultaneous push and pop:
   - Push 0x011 then 0x022, then assert push+pop with pcIn=0x0FF -> count=2, top=0x0FF; one pop then -> top=0x011.
   - From the empty stack, push+pop with pcIn=0x033 -> count=1, top=0x033, underflow=0.
6. Assert rst low mid-cycle while count=5 and push is high -> count=0, empty=1, and flags clear immediately, without waiting for a clock edge. Release rst and push 0x0AA -> top=0x0AA, count=1.
